// File: rtl/struct_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding,
// word geometry and the access-fault rule.
package struct_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int DMEM_WORD_BYTES  = 4;
    localparam int DMEM_OFFSET_BITS = $clog2(DMEM_WORD_BYTES);

    // Misaligned byte address or word index beyond the populated depth.
    function automatic logic dmem_fault(input logic [31:0] addr, input int depth);
        return (addr[DMEM_OFFSET_BITS-1:0] != '0) ||
               ({2'b00, addr[31:DMEM_OFFSET_BITS]} >= 32'(depth));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write and registered read, both
// qualified by one enable so a single access touches the array exactly once.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with a programmable number of wait
// states; one transaction in flight, memory accessed on the edge entering RESP.
module dmem_responder
    import struct_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    dmem_state_t state_reg, state_next;
    logic        run_reg;
    logic [3:0]  cnt_reg;
    logic        we_reg;
    logic        err_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;

    logic        accept;
    logic        enter_resp;
    logic        acc_we;
    logic        acc_err;
    logic        mem_en;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [31:0] mem_rdata;

    assign accept = req_valid && req_ready;

    // With zero wait states the access happens on the acceptance edge itself,
    // before the request fields have been latched, so take them from the port.
    assign acc_addr   = (state_reg == IDLE) ? req_addr  : addr_reg;
    assign acc_wdata  = (state_reg == IDLE) ? req_wdata : wdata_reg;
    assign acc_we     = (state_reg == IDLE) ? req_we    : we_reg;
    assign acc_err    = dmem_fault(acc_addr, DEPTH_WORDS);
    assign enter_resp = (state_next == RESP) && (state_reg != RESP);
    assign mem_en     = enter_resp && reset && !acc_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            run_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            run_reg   <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = (LATENCY > 0) ? WAIT : RESP;
            WAIT: if (cnt_reg <= 4'd1) state_next = RESP;
            RESP: if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_reg == IDLE) && run_reg;
        resp_valid = (state_reg == RESP);
        resp_err   = (state_reg == RESP) && err_reg;
        resp_rdata = ((state_reg == RESP) && !we_reg && !err_reg) ? mem_rdata : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
        end else if (accept) begin
            cnt_reg   <= 4'(LATENCY);
            we_reg    <= req_we;
            err_reg   <= acc_err;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
        end else if (state_reg == WAIT) begin
            cnt_reg <= cnt_reg - 4'd1;
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .en   (mem_en),
        .we   (acc_we),
        .addr (acc_addr[AW+1:2]),
        .wdata(acc_wdata),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) driven by
// directed and random transactions, checked against a word-array model.
module tb_dmem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid = '0, req_ready, req_we = '0;
    logic [1:0]  resp_valid, resp_ready = '0, resp_err;
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic [31:0] resp_rdata [2];

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] model [2][DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic logic exp_err(input logic [31:0] a);
        return ((a % 4) != 0) || ((a / 4) >= DEPTH);
    endfunction

    function automatic logic [31:0] exp_rdata(input int k, input logic we, input logic [31:0] a);
        if (exp_err(a) || we) return 32'd0;
        return model[k][a / 4];
    endfunction

    function automatic void model_apply(input int k, input logic we, input logic [31:0] a,
                                        input logic [31:0] d);
        if (we && !exp_err(a)) model[k][a / 4] = d;
    endfunction

    task automatic txn(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input int hold, output logic [31:0] rdata, output logic err,
                       output int lat, output bit stable);
        int n = 0;
        while (req_ready[k] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
        lat = 0;
        while (resp_valid[k] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rdata  = resp_rdata[k];
        err    = resp_err[k];
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (resp_valid[k] !== 1'b1 || resp_rdata[k] !== rdata ||
                resp_err[k] !== err || req_ready[k] !== 1'b0) stable = 1'b0;
        end
        resp_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready[k] = 1'b0;
        $display("txn dut%0d we=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 k, we, addr, wdata, rdata, err, lat);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b want 00", req_ready);
        else n_pass++;
        n_total++;
        if (resp_valid !== 2'b00 || resp_err !== 2'b00 || resp_rdata[0] !== 32'd0 || resp_rdata[1] !== 32'd0)
            $display("FAIL reset_resp: valid=%b err=%b rdata0=%h rdata1=%h want all 0",
                     resp_valid, resp_err, resp_rdata[0], resp_rdata[1]);
        else n_pass++;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if (req_ready !== 2'b11) $display("FAIL release_req_ready: got %b want 11", req_ready);
        else n_pass++;
    endtask

    task automatic test_fill();
        logic [31:0] rd, d;
        logic er;
        int lat;
        bit st;
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 32; w++) begin
                d = $urandom;
                txn(k, 1'b1, 32'(w * 4), d, 0, rd, er, lat, st);
                model_apply(k, 1'b1, 32'(w * 4), d);
                n_total++;
                if (rd !== 32'd0 || er !== 1'b0 || lat != lat_of(k))
                    $display("FAIL fill_store: dut%0d w=%0d rdata=%h err=%0d lat=%0d want 0/0/%0d",
                             k, w, rd, er, lat, lat_of(k));
                else n_pass++;
            end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic er;
        int lat;
        bit st;
        for (int k = 0; k < 2; k++) begin
            txn(k, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, rd, er, lat, st);
            model_apply(k, 1'b1, 32'h10, 32'hDEAD_BEEF);
            n_total++;
            if (lat != lat_of(k) || er !== 1'b0 || rd !== 32'd0)
                $display("FAIL store_basic: dut%0d lat=%0d err=%0d rdata=%h want %0d/0/0",
                         k, lat, er, rd, lat_of(k));
            else n_pass++;
            txn(k, 1'b0, 32'h10, 32'h0, 0, rd, er, lat, st);
            n_total++;
            if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat != lat_of(k))
                $display("FAIL load_basic: dut%0d rdata=%h err=%0d lat=%0d want deadbeef/0/%0d",
                         k, rd, er, lat, lat_of(k));
            else n_pass++;
            n_total++;
            if (resp_valid[k] !== 1'b0 || resp_rdata[k] !== 32'd0)
                $display("FAIL idle_outputs: dut%0d valid=%b rdata=%h want 0/0", k, resp_valid[k], resp_rdata[k]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic er;
        int lat;
        bit st;
        txn(0, 1'b0, 32'h10, 32'h0, 4, rd, er, lat, st);
        n_total++;
        if (st !== 1'b1 || rd !== 32'hDEAD_BEEF)
            $display("FAIL backpressure: stable=%0d rdata=%h want 1/deadbeef", st, rd);
        else n_pass++;
    endtask

    task automatic test_faults();
        logic [31:0] rd;
        logic er;
        int lat;
        bit st;
        txn(0, 1'b1, 32'h12, 32'h1234_5678, 0, rd, er, lat, st);
        n_total++;
        if (er !== 1'b1 || rd !== 32'd0) $display("FAIL misaligned_store: err=%0d rdata=%h want 1/0", er, rd);
        else n_pass++;
        txn(0, 1'b0, 32'h10, 32'h0, 0, rd, er, lat, st);
        n_total++;
        if (rd !== exp_rdata(0, 1'b0, 32'h10) || er !== 1'b0)
            $display("FAIL after_fault_load: rdata=%h err=%0d want %h/0", rd, er, exp_rdata(0, 1'b0, 32'h10));
        else n_pass++;
        txn(0, 1'b0, 32'h400, 32'h0, 0, rd, er, lat, st);
        n_total++;
        if (er !== 1'b1 || rd !== 32'd0) $display("FAIL range_load: err=%0d rdata=%h want 1/0", er, rd);
        else n_pass++;
        txn(0, 1'b1, 32'h3FC, 32'hA5A5_0FF0, 0, rd, er, lat, st);
        model_apply(0, 1'b1, 32'h3FC, 32'hA5A5_0FF0);
        txn(0, 1'b0, 32'h3FC, 32'h0, 0, rd, er, lat, st);
        n_total++;
        if (er !== 1'b0 || rd !== 32'hA5A5_0FF0) $display("FAIL last_word: err=%0d rdata=%h want 0/a5a50ff0", er, rd);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic er;
        int lat;
        bit st;
        txn(1, 1'b0, 32'h10, 32'h0, 1, rd, er, lat, st);
        n_total++;
        if (lat != 0 || st !== 1'b1 || rd !== 32'hDEAD_BEEF)
            $display("FAIL lat0_load: lat=%0d stable=%0d rdata=%h want 0/1/deadbeef", lat, st, rd);
        else n_pass++;
        n_total++;
        if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0)
            $display("FAIL idle_gap: req_ready=%b resp_valid=%b want 1/0", req_ready[1], resp_valid[1]);
        else n_pass++;
        txn(1, 1'b0, 32'h14, 32'h0, 0, rd, er, lat, st);
        n_total++;
        if (lat != 0 || rd !== exp_rdata(1, 1'b0, 32'h14))
            $display("FAIL lat0_second: lat=%0d rdata=%h want 0/%h", lat, rd, exp_rdata(1, 1'b0, 32'h14));
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, prior;
        logic er;
        int lat, seen;
        bit st;
        prior = model[0][8];
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h5555_5555;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        n_total++;
        if (resp_valid[0] !== 1'b0) $display("FAIL wait_no_resp: resp_valid=%b want 0", resp_valid[0]);
        else n_pass++;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if (req_ready[0] !== 1'b0 || resp_valid[0] !== 1'b0)
            $display("FAIL mid_reset_held: req_ready=%b resp_valid=%b want 0/0", req_ready[0], resp_valid[0]);
        else n_pass++;
        reset = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid[0] === 1'b1) seen++;
        end
        n_total++;
        if (seen != 0 || req_ready[0] !== 1'b1)
            $display("FAIL mid_reset_abandon: resp cycles=%0d req_ready=%b want 0/1", seen, req_ready[0]);
        else n_pass++;
        txn(0, 1'b0, 32'h20, 32'h0, 0, rd, er, lat, st);
        n_total++;
        if (rd !== prior) $display("FAIL mid_reset_no_write: rdata=%h want %h", rd, prior);
        else n_pass++;
    endtask

    task automatic test_ignored();
        logic [31:0] rd, er_data;
        logic er;
        int lat, acc, n;
        bit st;
        er_data = $urandom;
        acc = 0;
        n = 0;
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h30; req_wdata[0] = er_data;
        if (req_ready[0] === 1'b1) acc++;
        @(posedge clk);
        @(negedge clk);
        req_addr[0] = 32'h34; req_wdata[0] = ~er_data;
        while (resp_valid[0] !== 1'b1 && n < 40) begin
            if (req_ready[0] === 1'b1) acc++;
            @(negedge clk);
            n++;
        end
        resp_ready[0] = 1'b1;
        if (req_ready[0] === 1'b1) acc++;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        resp_ready[0] = 1'b0;
        model_apply(0, 1'b1, 32'h30, er_data);
        $display("txn dut0 held-valid store addr=00000030 wdata=%h acceptances=%0d", er_data, acc);
        n_total++;
        if (acc != 1 || n >= 40) $display("FAIL held_valid_accepts: got %0d want 1", acc);
        else n_pass++;
        txn(0, 1'b0, 32'h30, 32'h0, 0, rd, er, lat, st);
        n_total++;
        if (rd !== exp_rdata(0, 1'b0, 32'h30)) $display("FAIL held_valid_data: rdata=%h want %h", rd, exp_rdata(0, 1'b0, 32'h30));
        else n_pass++;
        txn(0, 1'b0, 32'h34, 32'h0, 0, rd, er, lat, st);
        n_total++;
        if (rd !== exp_rdata(0, 1'b0, 32'h34)) $display("FAIL ignored_no_write: rdata=%h want %h", rd, exp_rdata(0, 1'b0, 32'h34));
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d;
        logic er, we;
        int lat, sel;
        bit st;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 40; i++) begin
                we  = 1'($urandom_range(0, 1));
                sel = $urandom_range(0, 7);
                d   = $urandom;
                if (sel == 0)      a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
                else if (sel == 1) a = 32'(($urandom_range(0, 999) + DEPTH) * 4);
                else               a = 32'($urandom_range(0, 31) * 4);
                txn(k, we, a, d, $urandom_range(0, 2), rd, er, lat, st);
                n_total++;
                if (rd !== exp_rdata(k, we, a) || er !== exp_err(a) || lat != lat_of(k) || st !== 1'b1)
                    $display("FAIL random: dut%0d we=%0d addr=%h rdata=%h err=%0d lat=%0d want %h/%0d/%0d",
                             k, we, a, rd, er, lat, exp_rdata(k, we, a), exp_err(a), lat_of(k));
                else n_pass++;
                model_apply(k, we, a, d);
            end
        end
    endtask

    initial begin
        req_addr[0] = '0; req_addr[1] = '0;
        req_wdata[0] = '0; req_wdata[1] = '0;
        test_reset();
        test_fill();
        test_store_load();
        test_backpressure();
        test_faults();
        test_back_to_back();
        test_reset_mid();
        test_ignored();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameters SHALL be:
- DEPTH_WORDS, default 256, number of 32-bit data words.
- LATENCY, default 2, wait-state cycles per access; range 0..15.

REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  initiator accepts the response.
- resp_rdata  out  32  load data.
- resp_err  out  1  access fault.

REQ-003 The block SHALL use one clock, clk. Reset is synchronous and active-low on port reset; there is no asynchronous path.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.

REQ-005 req_ready SHALL be 1 only in IDLE. A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.

REQ-006 On acceptance, the block SHALL latch req_we, req_addr and req_wdata and load the wait counter with LATENCY. The next state SHALL be WAIT if LATENCY>0, otherwise RESP.

REQ-007 In WAIT, the counter SHALL decrement once per cycle. When the counter equals 1, the next state SHALL be RESP.

REQ-008 Access timing and write behaviour:
- The memory access SHALL occur on the edge that enters RESP.
- A store SHALL write exactly once per accepted request.

REQ-009 Latency: a request accepted at edge N SHALL produce resp_valid=1 starting at edge N+LATENCY+1.

REQ-010 In RESP:
- resp_valid, resp_rdata and resp_err SHALL hold stable until an edge with resp_ready=1.
- On that edge the next state SHALL be IDLE.

REQ-011 Back-to-back and simultaneous events:
- A new request SHALL NOT be accepted in the same cycle a response completes; req_ready rises the cycle after return to IDLE.
- At most one transaction SHALL be outstanding.

REQ-012 Word index SHALL be req_addr[31:2].

REQ-013 Fault conditions: resp_err=1 when req_addr[1:0]!=0 or the word index >= DEPTH_WORDS. A faulting access SHALL NOT modify memory and SHALL return resp_rdata=0.

REQ-014 Loads SHALL return the stored word. Stores SHALL return resp_rdata=0. Non-fault accesses SHALL return resp_err=0.

REQ-015 Outside RESP, resp_valid, resp_rdata and resp_err SHALL be 0.

REQ-016 A request with req_valid=1 outside IDLE SHALL be ignored and SHALL have no side effect.

Reset
REQ-017 While reset=0 at a clock edge, the block SHALL set:
- state = IDLE
- counter = 0
- all latched request fields = 0
- resp_valid = 0, resp_rdata = 0, resp_err = 0
- req_ready = 0 while reset is held.

REQ-018 req_ready SHALL be 1 on the first edge after reset is released.

REQ-019 Reset asserted in WAIT or RESP SHALL abandon the transaction with no memory write. Memory array contents SHALL NOT be cleared by reset.

Structure
REQ-020 The state enum dmem_state_t (IDLE, WAIT, RESP) and the constant DMEM_WORD_BYTES=4 SHALL live in the shared struct_pkg.

REQ-021 The storage array SHALL be a sub-module dmem_array (single port, synchronous write, DEPTH_WORDS x 32). The FSM and counter SHALL remain in dmem_responder.

REQ-022 The counter width SHALL be 4 bits. No combinational path SHALL exist from req_* inputs to req_ready.

Verification
REQ-023 Basic store then load, LATENCY=2:
- Store 0x0000_0010 <- 0xDEAD_BEEF, accepted at edge 5 -> resp_valid at edge 8, resp_err=0, resp_rdata=0.
- Load 0x10 -> resp_rdata=0xDEAD_BEEF.

REQ-024 Back-pressure: hold resp_ready=0 for 4 cycles during a load of 0x10 -> resp_valid and resp_rdata=0xDEAD_BEEF stay stable all 4 cycles; req_ready=0 throughout.

REQ-025 Faults:
- Store to 0x0000_0012 (misaligned) -> resp_err=1, resp_rdata=0; a later load of 0x10 is still 0xDEAD_BEEF.
- Load 0x0000_0400 with DEPTH_WORDS=256 -> resp_err=1.

REQ-026 LATENCY=0: a load accepted at edge N -> resp_valid at edge N+1. Back-to-back requests -> req_ready has one IDLE cycle between transactions.

REQ-027 Reset mid-operation: assert reset=0 while in WAIT during a store of 0x5555_5555 to 0x20 -> state returns to IDLE, no response is produced, and a load of 0x20 returns its prior value.

REQ-028 Ignored request: drive req_valid=1 continuously while in RESP -> exactly one transaction per acceptance edge; no duplicate writes.
